// File: rtl/grf_mp.sv
// grf_mp: dual-write general register file with read bypass and busy scoreboard.
// Ports:
//   clk, reset (async, active-low)
//   rd_addr / rd_data / rd_busy : NRD packed combinational read ports
//   we0/wa0/wd0/pc0             : write port 0 (older)
//   we1/wa1/wd1/pc1             : write port 1 (younger, wins collisions)
//   mk_en/mk_addr               : mark a register busy at issue
//   flush                       : clear every busy bit on the next edge
module grf_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic [31:0]           pc0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [31:0]           pc1,
  input  logic                  mk_en,
  input  logic [ADDR_W-1:0]     mk_addr,
  input  logic                  flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic wr0;
  logic wr1;
  logic mk;

  assign wr0 = we0 && (wa0 != '0);
  assign wr1 = we1 && (wa1 != '0);
  assign mk  = mk_en && (mk_addr != '0);

  // Port 1 is issued later in the same edge, so its
  // non-blocking update overrides port 0 on a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0) regs[wa0] <= wd0;
      if (wr1) regs[wa1] <= wd1;
    end
  end

  // A fresh mark supersedes a retiring write-back
  // to the same register, so the set goes last.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr0) busy_nxt[wa0] = 1'b0;
      if (wr1) busy_nxt[wa1] = 1'b0;
      if (mk)  busy_nxt[mk_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  genvar k;
  for (k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0;
    logic              hit1;

    assign a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit1 = wr1 && (wa1 == a);
    assign hit0 = wr0 && (wa0 == a);

    assign rd_data[k*DATA_W +: DATA_W] =
      (!reset || (a == '0)) ? '0  :
      hit1                  ? wd1 :
      hit0                  ? wd0 :
                              regs[a];

    // A same-cycle write-back is bypassed, so no stall.
    assign rd_busy[k] = reset && (a != '0) && busy[a]
                        && !(hit0 || hit1);
  end

`ifndef SYNTHESIS
  logic tr0;
  logic tr1;

  assign tr1 = reset && wr1;
  assign tr0 = reset && wr0 && !(wr1 && (wa1 == wa0));

  always @(posedge clk) begin
    if (tr0) $display("%d@%h: $%d <= %h", $time, pc0, wa0, wd0);
    if (tr1) $display("%d@%h: $%d <= %h", $time, pc1, wa1, wd1);
  end
`endif

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised general register file for the dual-issue pipeline. Successor to the single-write 2-read GRF.
- Provides NRD combinational read ports, two prioritised write-back ports, and write-to-read bypass.
- Adds a per-register busy scoreboard: set at issue, cleared at write-back. Decode uses it for stall generation.
- Sits between decode (reads, busy marking) and write-back (two writes per cycle).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NRD, 3, number of read ports

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all registers and busy bits immediately
rd_addr  input  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
rd_busy  output  NRD  port k's register has an outstanding producer
we0, wa0, wd0, pc0  input  1/ADDR_W/DATA_W/32  write port 0 (older instruction): enable, address, data, PC for trace
we1, wa1, wd1, pc1  input  1/ADDR_W/DATA_W/32  write port 1 (younger instruction): same fields; higher priority
mk_en  input  1  mark a register busy (producer issued)
mk_addr  input  ADDR_W  register to mark
flush  input  1  synchronous clear of all busy bits; register contents are unaffected

Behaviour:
- Storage: 2**ADDR_W x DATA_W array plus a busy vector of 2**ADDR_W bits.
- Register 0 always reads 0, is never written, and is never busy. Writes and marks to address 0 are ignored.
- Reset (reset==0, asynchronous):
  - all registers = 0 and busy = 0 without waiting for a clock edge;
  - rd_data reads 0 and rd_busy reads 0 for every port while reset is low;
  - writes, marks and flush are ignored while reset is low;
  - deassertion takes effect at the next rising edge.
- Write, on the rising edge with reset==1:
  - port j writes if wej && waj!=0;
  - if both ports target the same nonzero address, port 1's data is stored;
  - writes to different addresses both take effect.
- Read (combinational, zero latency), per port k with address a:
  - a==0 gives 0;
  - else if we1 && wa1==a, gives wd1;
  - else if we0 && wa0==a, gives wd0;
  - else gives array[a].
- Busy update, on the rising edge with reset==1, applied in this priority order (highest first):
  1. flush: busy = 0 entirely; mk_en is ignored that cycle.
  2. mk_en && mk_addr!=0: busy[mk_addr] = 1. This wins over a same-cycle write to the same address, because a new producer supersedes the retiring one.
  3. A write (we0 or we1) to address a!=0 clears busy[a] unless rule 2 marks a.
- rd_busy[k] = busy[a] && !(write to a this cycle) && a!=0. A same-cycle write-back resolves the hazard through the bypass, so the port reports not busy. Marking in the current cycle does not affect rd_busy until the next cycle.
- Trace (simulation only, not synthesised): on each committed write, print time, PC, register and data, in the format "%d@%h: $%d <= %h".
  - Print port 0 before port 1.
  - On a same-address collision, port 0's write is not printed.
- Width rules: no arithmetic. All addresses compare at the full ADDR_W bits.

Test Plan:
- Reset mid-operation: write 0x1234_5678 to r5 and mark r7; pulse reset low between clock edges -> rd_data(r5)=0 and rd_busy(r7)=0 immediately, without a clock edge.
- Dual write collision: we0=we1=1, wa0=wa1=8, wd0=0xAAAA_AAAA, wd1=0x5555_5555 -> same-cycle read of r8 gives 0x5555_5555; after the edge r8=0x5555_5555; only the port 1 trace line prints.
- Bypass on all ports: NRD=3, all ports read r9 while we0 writes 0xDEAD_BEEF to r9 -> all three ports read 0xDEAD_BEEF that cycle; r9 holds it next cycle.
- Scoreboard lifecycle:
  - mark r3 -> rd_busy=1 from the next cycle;
  - write-back to r3 -> rd_busy=0 in the write cycle (bypass) and after it;
  - mark and write r3 in the same cycle -> busy stays 1.
- Register zero: write 0xFFFF_FFFF to r0 on both ports and mark r0 -> reads 0, rd_busy=0, no trace line printed.
- Flush: mark r1, r2 and r31; flush with mk_en=1 on r4 -> all busy bits are 0, r4 is not busy, and register contents are unchanged.
